// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES job control path.
// Holds the job FSM state encoding and default sizing.
package aes_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_RESP
   } aes_job_state_t;

   localparam int AES_TIMEOUT_DEF = 31;
   localparam int AES_BLK_W = 128;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin picker: first set request above
// last_grant, wrapping modulo NREQ.
module aes_rr_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   logic          found;
   logic [IW-1:0] j;

   always_comb begin
      grant = '0;
      idx = '0;
      found = 1'b0;
      j = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = IW'((int'(last_grant) + k) % NREQ);
         if (!found && req[j]) begin
            found = 1'b1;
            grant[j] = 1'b1;
            idx = j;
         end
      end
   end

endmodule

// File: rtl/aes_job_arbiter.sv
// Multiplexes NREQ requesters onto one AES core, one job in
// flight, with round-robin grant, core timeout and response hold.
module aes_job_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TIMEOUT = AES_TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*AES_BLK_W-1:0] req_key,
   input  logic [NREQ*AES_BLK_W-1:0] req_text,
   output logic                      core_ld,
   output logic [AES_BLK_W-1:0]      core_key,
   output logic [AES_BLK_W-1:0]      core_text,
   input  logic                      core_done,
   input  logic [AES_BLK_W-1:0]      core_text_out,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [AES_BLK_W-1:0]      rsp_data,
   output logic                      rsp_err,
   output logic                      busy
);

   localparam int IW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT + 1);

   aes_job_state_t state_q;
   aes_job_state_t state_d;

   logic [IW-1:0]        last_grant;
   logic [IW-1:0]        id_q;
   logic [AES_BLK_W-1:0] key_q;
   logic [AES_BLK_W-1:0] text_q;
   logic [AES_BLK_W-1:0] data_q;
   logic                 err_q;
   logic [TW-1:0]        timer;
   logic [TW-1:0]        timer_inc;
   logic                 timeout_hit;
   logic                 accept;
   logic [NREQ-1:0]      grant;
   logic [IW-1:0]        gidx;

   logic [AES_BLK_W-1:0] key_arr  [NREQ];
   logic [AES_BLK_W-1:0] text_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign key_arr[i]  = req_key[i*AES_BLK_W +: AES_BLK_W];
      assign text_arr[i] = req_text[i*AES_BLK_W +: AES_BLK_W];
   end

   aes_rr_arbiter #(
      .NREQ(NREQ),
      .IW  (IW)
   ) u_rr (
      .req       (req_valid),
      .last_grant(last_grant),
      .grant     (grant),
      .idx       (gidx)
   );

   assign timer_inc   = timer + TW'(1);
   assign timeout_hit = (timer_inc == TW'(TIMEOUT));
   assign accept      = (state_q == ST_IDLE) && (|req_valid);

   always_comb begin
      state_d = state_q;
      req_ready = '0;
      core_ld = 1'b0;
      rsp_valid = 1'b0;
      busy = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (|req_valid) begin
               // never strobe a requester while reset is held
               req_ready = rst ? grant : '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            core_ld = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (core_done || timeout_hit)
               state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         last_grant <= IW'(NREQ - 1);
         id_q       <= '0;
         key_q      <= '0;
         text_q     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         timer      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant <= gidx;
            id_q       <= gidx;
            key_q      <= key_arr[gidx];
            text_q     <= text_arr[gidx];
         end
         if (state_q == ST_LOAD)
            timer <= '0;
         // done wins over a coincident timeout
         if (state_q == ST_RUN) begin
            if (core_done) begin
               data_q <= core_text_out;
               err_q  <= 1'b0;
            end else begin
               timer <= timer_inc;
               if (timeout_hit) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign core_key  = key_q;
   assign core_text = text_q;
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 31, giving the maximum number of RUN cycles to wait for core_done.
REQ-003 Port clk, input, 1: clock; all logic SHALL be on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-low.
REQ-005 Port req_valid, input, NREQ: per-requester job pending.
REQ-006 Port req_ready, output, NREQ: one-hot job-accept strobe.
REQ-007 Port req_key, input, NREQ*128: per-requester key; requester i uses bits [128*i+127:128*i].
REQ-008 Port req_text, input, NREQ*128: per-requester plaintext, sliced like req_key.
REQ-009 Port core_ld, output, 1: load pulse to the cipher core.
REQ-010 Port core_key, output, 128: key to the core.
REQ-011 Port core_text, output, 128: plaintext to the core.
REQ-012 Port core_done, input, 1: cipher core done pulse.
REQ-013 Port core_text_out, input, 128: cipher core result.
REQ-014 Port rsp_valid, output, 1: response available.
REQ-015 Port rsp_ready, input, 1: response consumer ready.
REQ-016 Port rsp_id, output, $clog2(NREQ): index of the requester that owns the response.
REQ-017 Port rsp_data, output, 128: ciphertext.
REQ-018 Port rsp_err, output, 1: core timed out.
REQ-019 Port busy, output, 1: high in every state except IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, RUN and RESP, and only one job SHALL be in flight at a time.
REQ-021 In IDLE, when req_valid is non-zero, the block SHALL grant the first set bit found searching from last_grant+1 upward, modulo NREQ.
REQ-022 In that same IDLE cycle, it SHALL assert req_ready for the granted requester only, latch that requester's key, text and id, update last_grant, and go to LOAD.
REQ-023 A requester SHALL be able to drop req_valid without ready; an unaccepted request carries no state.
REQ-024 LOAD SHALL last exactly one cycle, with core_ld=1; the FSM then goes to RUN and clears the timer.
REQ-025 core_key and core_text SHALL be driven from the latched registers and held stable from LOAD until the FSM leaves RESP.
REQ-026 core_done seen in LOAD SHALL be ignored as stale.
REQ-027 In RUN, core_done=1 SHALL capture core_text_out into rsp_data, set rsp_err=0, and go to RESP.
REQ-028 In RUN without core_done, the timer SHALL increment; when it equals TIMEOUT, the block SHALL set rsp_err=1 and rsp_data=0 and go to RESP.
REQ-029 core_done and the timeout in the same cycle SHALL resolve as done.
REQ-030 In RESP, rsp_valid SHALL be 1 and rsp_id, rsp_data and rsp_err SHALL be stable until rsp_ready=1.
REQ-031 On the rsp_ready handshake, the FSM SHALL return to IDLE and drop rsp_valid the next cycle.
REQ-032 The block SHALL NOT accept a new request in the handshake cycle; the earliest re-grant is the following IDLE cycle.
REQ-033 With core_done 12 cycles after core_ld, acceptance at cycle T SHALL give core_ld at T+1 and rsp_valid at T+14.
REQ-034 The timer SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-035 When rst=0, the block SHALL go to IDLE with req_ready=0, core_ld=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_id=0, busy=0, timer=0, and core_key/core_text=0.
REQ-036 Reset SHALL set last_grant=NREQ-1, so that requester 0 has first priority.
REQ-037 Reset asserted mid-job, in any state, SHALL discard the job with no response issued; a core_done arriving after reset release SHALL be ignored.

Structure
REQ-038 A shared package aes_ctrl_pkg SHALL hold the state enum (aes_job_state_t), the default TIMEOUT constant and the block width constant (128).
REQ-039 Round-robin selection SHALL be a sub-module aes_rr_arbiter that takes req and last_grant and returns a one-hot grant and an index; it is combinational and instantiated once.

Verification
REQ-040 Single job: req_valid=4'b0001 with key 000102..0f and text 00112233..ff, and the core model returns 69c4e0d8..70b4c55a 12 cycles after ld -> req_ready[0] at T, core_ld at T+1, rsp_valid at T+14 with rsp_id=0, rsp_data=69c4e0d8..70b4c55a, rsp_err=0.
REQ-041 Fairness: req_valid=4'b1111 held with rsp_ready=1 -> grant order 0,1,2,3,0 and each response carries the matching rsp_id.
REQ-042 Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> outputs stable, no req_ready, and busy=1 throughout; release -> IDLE next cycle.
REQ-043 Timeout: the core model never asserts done -> rsp_err=1 and rsp_data=0 after TIMEOUT RUN cycles; the next job proceeds normally.
REQ-044 Reset mid-RUN: rst=0 for 1 cycle at RUN cycle 5 -> all outputs at their reset values; a late core_done produces no rsp_valid; after release, requester 0 is granted first.
REQ-045 Corner case: core_done in the LOAD cycle and simultaneous done/timeout -> the first is ignored and the second is treated as done (rsp_err=0).
